gcn_aggregate_argmax: RTL and testbench
=======================================

# gcn_aggregate_argmax

Downstream stage of the GCN datapath. Once the FM×WM product matrix sits in the FM_WM matrix memory, this block walks the COO edge list and accumulates each node's neighbour rows into per-node aggregates. It then computes a per-node argmax over the WEIGHT_COLS classes. It drives the memory read row and the COO column address, and produces `max_addi_answer` and `done` for the top level.

## Interface
- FEATURE_ROWS, 6, number of graph nodes / product rows
- WEIGHT_COLS, 3, classes per row
- DOT_PROD_WIDTH, 16, unsigned product element width
- COO_NUM_OF_COLS, 6, number of COO edges
- COO_BW, $clog2(COO_NUM_OF_COLS), COO address and node-index width
- AGG_WIDTH, DOT_PROD_WIDTH+$clog2(2*COO_NUM_OF_COLS+1), aggregate width
- MAX_ADDRESS_WIDTH, 2, argmax index width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  level-sampled request to begin, honoured only in IDLE
- fm_wm_row_in  in  [DOT_PROD_WIDTH-1:0] x WEIGHT_COLS  product row selected by read_row, valid the same cycle
- coo_in  in  [COO_BW-1:0] x 2  COO column at coo_address; [0]=src, [1]=dst, 1-based node ids; valid the same cycle
- read_row  out  $clog2(FEATURE_ROWS)  registered memory row select
- coo_address  out  COO_BW  registered COO column select
- max_addi_answer  out  [MAX_ADDRESS_WIDTH-1:0] x FEATURE_ROWS  registered argmax per node
- done  out  1  registered, high when results are valid

## Operation
- The FSM has the states IDLE, INIT, E_FETCH, E_SRC, E_DST, ARGMAX and DONE.
- IDLE: on `start`, clear `done`, `max_addi_answer`, `read_row`, `coo_address` and the node counter, then go to INIT.
- INIT: see Configuration.
- E_FETCH: latch src=coo_in[0] and dst=coo_in[1].
  - If either id is 0 or greater than FEATURE_ROWS, the edge is skipped: advance coo_address and stay in E_FETCH, or go to ARGMAX after the last edge.
  - Otherwise set read_row<=src-1 and go to E_SRC.
- E_SRC: agg[dst-1] += fm_wm_row_in, element-wise.
  - If src==dst, advance the edge and go to E_FETCH or ARGMAX. A self-edge is added once.
  - Otherwise set read_row<=dst-1 and go to E_DST.
- E_DST: agg[src-1] += fm_wm_row_in; advance the edge. The graph is undirected.
- ARGMAX: one node per cycle, max_addi_answer[n] <= index of the largest agg[n] element. On a tie, the lowest index wins. After node FEATURE_ROWS-1, go to DONE.
- DONE: `done`=1; hold all outputs until the next `start`, then restart as from IDLE.
- Arithmetic is unsigned with zero-extension to AGG_WIDTH. AGG_WIDTH guarantees no overflow, so there is no wrap and no saturation.
- `start` outside IDLE and DONE is ignored.

## Timing
- Reset values: every output 0, including `done`, `read_row`, `coo_address` and all `max_addi_answer[n]`. Aggregates are cleared and the state is IDLE.
- Reset during operation aborts immediately. No partial results remain, and the block waits for a new `start`.
- Edge cost: 3 cycles for distinct valid nodes, 2 for a self-edge, 1 for a skipped edge.
- With defaults, the macro defined and 6 valid distinct edges: `start` is sampled at edge 0, and `done` is high after edge 30 (INIT 6 + edges 18 + ARGMAX 6).
- Without the macro the same case finishes at edge 25.

## Configuration
- `GCN_AGG_SELF_LOOP_EN` defined: INIT takes FEATURE_ROWS cycles. It reads rows 0..FEATURE_ROWS-1 through read_row and loads agg[n]=row n (self-loop included).
- Undefined: INIT is one cycle that zeroes all aggregates, so neighbour rows only are summed.

## Structure
- `gcn_pkg` holds the state enum and the width constants shared with the multiplication stage.
- One sub-module, `gcn_argmax`: combinational WEIGHT_COLS-way unsigned comparator, lowest index on tie.

## Test plan
- All COO entries 0, every row {5,9,9}, macro on → all answers 1; done after edge 18.
- Edge (1,2) with row0={10,0,0}, row1={0,20,0}, other rows {0,0,1}, remaining edges padding → answers {1,1,2,2,2,2}.
- Edge (3,3) alone with row2={4,0,3} → answer[2]=0; done one cycle earlier than an equivalent distinct edge.
- Edge (7,1) → skipped; answer[0] equals its self-only argmax; costs 1 cycle.
- reset low during E_SRC → all outputs 0 next cycle; a new start gives correct results.
- start pulsed during ARGMAX → ignored, completion cycle unchanged; start in DONE → done drops next cycle and the run repeats.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared constants and FSM state encoding for the GCN aggregate/argmax stage.
package gcn_pkg;

  localparam int FEATURE_ROWS_D      = 6;
  localparam int WEIGHT_COLS_D       = 3;
  localparam int DOT_PROD_WIDTH_D    = 16;
  localparam int COO_NUM_OF_COLS_D   = 6;
  localparam int MAX_ADDRESS_WIDTH_D = 2;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    E_FETCH,
    E_SRC,
    E_DST,
    ARGMAX,
    DONE
  } state_t;

endpackage

// File: rtl/gcn_argmax.sv
// Combinational WEIGHT_COLS-way unsigned argmax; the lowest index wins a tie.
module gcn_argmax
  import gcn_pkg::*;
#(
  parameter int WEIGHT_COLS       = WEIGHT_COLS_D,
  parameter int AGG_WIDTH         = 20,
  parameter int MAX_ADDRESS_WIDTH = MAX_ADDRESS_WIDTH_D
) (
  input  logic [WEIGHT_COLS-1:0][AGG_WIDTH-1:0] vals,
  output logic [MAX_ADDRESS_WIDTH-1:0]          idx
);

  logic [AGG_WIDTH-1:0] best;

  // Strict greater-than keeps the earlier index on equal values.
  always_comb begin
    best = vals[0];
    idx  = '0;
    for (int i = 1; i < WEIGHT_COLS; i++) begin
      if (vals[i] > best) begin
        best = vals[i];
        idx  = MAX_ADDRESS_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/gcn_aggregate_argmax.sv
// Walks the COO edge list, accumulates neighbour product rows per node, then argmaxes each node.
// GCN_AGG_SELF_LOOP_EN: when defined, INIT seeds each aggregate with the node's own row.
module gcn_aggregate_argmax
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS      = FEATURE_ROWS_D,
  parameter int WEIGHT_COLS       = WEIGHT_COLS_D,
  parameter int DOT_PROD_WIDTH    = DOT_PROD_WIDTH_D,
  parameter int COO_NUM_OF_COLS   = COO_NUM_OF_COLS_D,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int AGG_WIDTH         = DOT_PROD_WIDTH + $clog2(2*COO_NUM_OF_COLS+1),
  parameter int MAX_ADDRESS_WIDTH = MAX_ADDRESS_WIDTH_D
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]   fm_wm_row_in,
  input  logic [1:0][COO_BW-1:0]                       coo_in,
  output logic [$clog2(FEATURE_ROWS)-1:0]              read_row,
  output logic [COO_BW-1:0]                            coo_address,
  output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] max_addi_answer,
  output logic                                         done
);

  localparam int ROW_W = $clog2(FEATURE_ROWS);

  typedef logic [WEIGHT_COLS-1:0][AGG_WIDTH-1:0] agg_row_t;

  state_t                         state;
  agg_row_t [FEATURE_ROWS-1:0]    agg;
  logic [COO_BW-1:0]              src;
  logic [COO_BW-1:0]              dst;
  logic [ROW_W-1:0]               node;
  logic [MAX_ADDRESS_WIDTH-1:0]   node_max;
  logic                           last_edge;

  function automatic agg_row_t widen_row(input logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row);
    agg_row_t r;
    for (int c = 0; c < WEIGHT_COLS; c++) r[c] = AGG_WIDTH'(row[c]);
    return r;
  endfunction

  // AGG_WIDTH covers the worst-case sum, so a plain add never wraps.
  function automatic agg_row_t add_row(input agg_row_t acc,
                                       input logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row);
    agg_row_t r;
    for (int c = 0; c < WEIGHT_COLS; c++) r[c] = acc[c] + AGG_WIDTH'(row[c]);
    return r;
  endfunction

  function automatic logic id_ok(input logic [COO_BW-1:0] id);
    return (id != '0) && (int'(id) <= FEATURE_ROWS);
  endfunction

  assign last_edge = (coo_address == COO_BW'(COO_NUM_OF_COLS - 1));

  gcn_argmax #(
    .WEIGHT_COLS      (WEIGHT_COLS),
    .AGG_WIDTH        (AGG_WIDTH),
    .MAX_ADDRESS_WIDTH(MAX_ADDRESS_WIDTH)
  ) u_argmax (
    .vals(agg[node]),
    .idx (node_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      read_row        <= '0;
      coo_address     <= '0;
      max_addi_answer <= '0;
      done            <= 1'b0;
      agg             <= '0;
      src             <= '0;
      dst             <= '0;
      node            <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done            <= 1'b0;
            max_addi_answer <= '0;
            read_row        <= '0;
            coo_address     <= '0;
            node            <= '0;
            state           <= INIT;
          end
        end

`ifdef GCN_AGG_SELF_LOOP_EN
        // read_row walks 0..FEATURE_ROWS-1; each row seeds its own aggregate.
        INIT: begin
          agg[read_row] <= widen_row(fm_wm_row_in);
          if (read_row == ROW_W'(FEATURE_ROWS - 1)) begin
            read_row <= '0;
            state    <= E_FETCH;
          end else begin
            read_row <= read_row + 1'b1;
          end
        end
`else
        INIT: begin
          agg   <= '0;
          state <= E_FETCH;
        end
`endif

        E_FETCH: begin
          src <= coo_in[0];
          dst <= coo_in[1];
          if (id_ok(coo_in[0]) && id_ok(coo_in[1])) begin
            read_row <= ROW_W'(coo_in[0] - 1'b1);
            state    <= E_SRC;
          end else if (last_edge) begin
            node  <= '0;
            state <= ARGMAX;
          end else begin
            coo_address <= coo_address + 1'b1;
          end
        end

        E_SRC: begin
          agg[ROW_W'(dst - 1'b1)] <= add_row(agg[ROW_W'(dst - 1'b1)], fm_wm_row_in);
          if (src != dst) begin
            read_row <= ROW_W'(dst - 1'b1);
            state    <= E_DST;
          end else if (last_edge) begin
            node  <= '0;
            state <= ARGMAX;
          end else begin
            coo_address <= coo_address + 1'b1;
            state       <= E_FETCH;
          end
        end

        E_DST: begin
          agg[ROW_W'(src - 1'b1)] <= add_row(agg[ROW_W'(src - 1'b1)], fm_wm_row_in);
          if (last_edge) begin
            node  <= '0;
            state <= ARGMAX;
          end else begin
            coo_address <= coo_address + 1'b1;
            state       <= E_FETCH;
          end
        end

        ARGMAX: begin
          max_addi_answer[node] <= node_max;
          if (node == ROW_W'(FEATURE_ROWS - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            node <= node + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_aggregate_argmax.sv
// Self-checking bench for gcn_aggregate_argmax against a behavioural graph-aggregation model.
module tb_gcn_aggregate_argmax;

  localparam int FR = 6;
  localparam int WC = 3;
  localparam int DW = 16;
  localparam int NC = 6;
  localparam int CB = 3;
  localparam int MW = 2;
  localparam int LIMIT = 200;
`ifdef GCN_AGG_SELF_LOOP_EN
  localparam int INIT_CYC = FR;
  localparam bit SELF = 1'b1;
`else
  localparam int INIT_CYC = 1;
  localparam bit SELF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [WC-1:0][DW-1:0]  fm_wm_row_in;
  logic [1:0][CB-1:0]     coo_in;
  logic [2:0]             read_row;
  logic [CB-1:0]          coo_address;
  logic [FR-1:0][MW-1:0]  max_addi_answer;
  logic                   done;

  logic [DW-1:0] mem [FR][WC];
  logic [CB-1:0] csrc [NC];
  logic [CB-1:0] cdst [NC];

  int checks = 0;
  int failures = 0;
  logic [FR-1:0][MW-1:0] exp_ans;
  int exp_cyc;

  gcn_aggregate_argmax dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .fm_wm_row_in   (fm_wm_row_in),
    .coo_in         (coo_in),
    .read_row       (read_row),
    .coo_address    (coo_address),
    .max_addi_answer(max_addi_answer),
    .done           (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < WC; c++)
      fm_wm_row_in[c] = (int'(read_row) < FR) ? mem[int'(read_row)][c] : '0;
    coo_in[0] = (int'(coo_address) < NC) ? csrc[int'(coo_address)] : '0;
    coo_in[1] = (int'(coo_address) < NC) ? cdst[int'(coo_address)] : '0;
  end

  // Reference: undirected neighbour sums (plus optional self row), argmax, cycle cost.
  task automatic model();
    longint agg [FR][WC];
    int s, d, best;
    exp_cyc = INIT_CYC + FR;
    for (int n = 0; n < FR; n++)
      for (int c = 0; c < WC; c++) agg[n][c] = SELF ? longint'(mem[n][c]) : 0;
    for (int e = 0; e < NC; e++) begin
      s = int'(csrc[e]);
      d = int'(cdst[e]);
      if (s < 1 || s > FR || d < 1 || d > FR) begin
        exp_cyc += 1;
      end else begin
        for (int c = 0; c < WC; c++) agg[d-1][c] += longint'(mem[s-1][c]);
        if (s != d) begin
          for (int c = 0; c < WC; c++) agg[s-1][c] += longint'(mem[d-1][c]);
          exp_cyc += 3;
        end else begin
          exp_cyc += 2;
        end
      end
    end
    for (int n = 0; n < FR; n++) begin
      best = 0;
      for (int c = 1; c < WC; c++) if (agg[n][c] > agg[n][best]) best = c;
      exp_ans[n] = MW'(best);
    end
  endtask

  task automatic clear_coo();
    for (int e = 0; e < NC; e++) begin
      csrc[e] = '0;
      cdst[e] = '0;
    end
  endtask

  task automatic rand_mem();
    for (int n = 0; n < FR; n++)
      for (int c = 0; c < WC; c++) mem[n][c] = DW'($urandom);
  endtask

  task automatic set_row(input int n, input int a, input int b, input int c);
    mem[n][0] = DW'(a);
    mem[n][1] = DW'(b);
    mem[n][2] = DW'(c);
  endtask

  // Start sampled at edge 0; cyc = edge number at which done is first seen high, -1 on timeout.
  task automatic run_job(input int pulse_at, output int cyc, output logic d0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done;
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      start = (cyc + 1 == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++;
    if (read_row !== '0) begin failures++; $display("FAIL reset_read_row got=%0d want=0", read_row); end
    checks++;
    if (coo_address !== '0) begin failures++; $display("FAIL reset_coo_address got=%0d want=0", coo_address); end
    checks++;
    if (max_addi_answer !== '0) begin failures++; $display("FAIL reset_answers got=%h want=0", max_addi_answer); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_skip();
    int cyc; logic d0;
    clear_coo();
    for (int n = 0; n < FR; n++) set_row(n, 5, 9, 9);
    model();
    run_job(0, cyc, d0);
    checks++;
    if (cyc !== exp_cyc) begin failures++; $display("FAIL all_skip_cycles got=%0d want=%0d", cyc, exp_cyc); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL all_skip_answers got=%h want=%h", max_addi_answer, exp_ans); end
  endtask

  task automatic test_pair();
    int cyc; logic d0;
    clear_coo();
    csrc[0] = 3'd1; cdst[0] = 3'd2;
    set_row(0, 10, 0, 0);
    set_row(1, 0, 20, 0);
    for (int n = 2; n < FR; n++) set_row(n, 0, 0, 1);
    model();
    run_job(0, cyc, d0);
    checks++;
    if (cyc !== exp_cyc) begin failures++; $display("FAIL pair_cycles got=%0d want=%0d", cyc, exp_cyc); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL pair_answers got=%h want=%h", max_addi_answer, exp_ans); end
  endtask

  task automatic test_self_edge();
    int cyc_self, cyc_dist; logic d0;
    rand_mem();
    set_row(2, 4, 0, 3);
    clear_coo();
    csrc[0] = 3'd3; cdst[0] = 3'd3;
    model();
    run_job(0, cyc_self, d0);
    checks++;
    if (cyc_self !== exp_cyc) begin failures++; $display("FAIL self_cycles got=%0d want=%0d", cyc_self, exp_cyc); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL self_answers got=%h want=%h", max_addi_answer, exp_ans); end
    checks++;
    if (max_addi_answer[2] !== 2'd0) begin failures++; $display("FAIL self_answer2 got=%0d want=0", max_addi_answer[2]); end
    cdst[0] = 3'd4;
    model();
    run_job(0, cyc_dist, d0);
    checks++;
    if (cyc_dist !== cyc_self + 1) begin failures++; $display("FAIL self_vs_distinct got=%0d want=%0d", cyc_dist, cyc_self + 1); end
  endtask

  task automatic test_skip();
    int cyc; logic d0;
    rand_mem();
    clear_coo();
    csrc[0] = 3'd7; cdst[0] = 3'd1;
    model();
    run_job(0, cyc, d0);
    checks++;
    if (cyc !== INIT_CYC + NC + FR) begin failures++; $display("FAIL skip_cycles got=%0d want=%0d", cyc, INIT_CYC + NC + FR); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL skip_answers got=%h want=%h", max_addi_answer, exp_ans); end
  endtask

  task automatic test_random();
    int cyc; logic d0;
    for (int it = 0; it < 8; it++) begin
      rand_mem();
      for (int e = 0; e < NC; e++) begin
        csrc[e] = CB'($urandom_range(0, 7));
        cdst[e] = CB'($urandom_range(0, 7));
      end
      model();
      run_job(0, cyc, d0);
      checks++;
      if (cyc !== exp_cyc) begin failures++; $display("FAIL rand%0d_cycles got=%0d want=%0d", it, cyc, exp_cyc); end
      checks++;
      if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL rand%0d_answers got=%h want=%h", it, max_addi_answer, exp_ans); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; logic d0;
    rand_mem();
    clear_coo();
    csrc[0] = 3'd4; cdst[0] = 3'd2;
    csrc[1] = 3'd5; cdst[1] = 3'd6;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (INIT_CYC + 1) begin @(posedge clk); #1; end
    checks++;
    if (read_row !== 3'd3) begin failures++; $display("FAIL mid_pre_read_row got=%0d want=3", read_row); end
    reset = 1'b0;
    #1;
    checks++;
    if ({read_row, coo_address, done} !== '0) begin
      failures++; $display("FAIL mid_reset_ctrl got=%0d/%0d/%b want=0/0/0", read_row, coo_address, done);
    end
    @(posedge clk); #1;
    checks++;
    if (max_addi_answer !== '0 || done !== 1'b0) begin
      failures++; $display("FAIL mid_reset_outputs got=%h/%b want=0/0", max_addi_answer, done);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    model();
    run_job(0, cyc, d0);
    checks++;
    if (cyc !== exp_cyc) begin failures++; $display("FAIL mid_rerun_cycles got=%0d want=%0d", cyc, exp_cyc); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL mid_rerun_answers got=%h want=%h", max_addi_answer, exp_ans); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic d0;
    rand_mem();
    clear_coo();
    for (int e = 0; e < NC; e++) begin
      csrc[e] = CB'($urandom_range(1, FR));
      cdst[e] = CB'($urandom_range(1, FR));
    end
    model();
    run_job(exp_cyc - 3, cyc, d0);
    checks++;
    if (cyc !== exp_cyc) begin failures++; $display("FAIL argmax_start_cycles got=%0d want=%0d", cyc, exp_cyc); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL argmax_start_answers got=%h want=%h", max_addi_answer, exp_ans); end
    rand_mem();
    model();
    run_job(0, cyc, d0);
    checks++;
    if (d0 !== 1'b0) begin failures++; $display("FAIL restart_done_drop got=%b want=0", d0); end
    checks++;
    if (cyc !== exp_cyc) begin failures++; $display("FAIL restart_cycles got=%0d want=%0d", cyc, exp_cyc); end
    checks++;
    if (max_addi_answer !== exp_ans) begin failures++; $display("FAIL restart_answers got=%h want=%h", max_addi_answer, exp_ans); end
  endtask

  initial begin
    rand_mem();
    clear_coo();
    test_reset();
    test_all_skip();
    test_pair();
    test_self_edge();
    test_skip();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
